// File: rtl/spi_master_n.sv
// SPI shift engine behind the $FE30-$FE37 I/O decode: chip selects, SCLK divider,
// four SPI modes, LSB/MSB-first order and auto-restart block reads.
//   state   | meaning
//   S_IDLE  | no transfer; SCLK parked at CPOL
//   S_SHIFT | 16 SCLK edges being generated; BUSY=1
module spi_master_n #(
  parameter int          NCS     = 4,
  parameter logic [7:0]  DIV_RST = 8'd59,
  parameter int          NIN     = 4
) (
  input  logic                            MHZ48,
  input  logic                            RES,
  input  logic [2:0]                      A,
  input  logic [7:0]                      DI,
  output logic [7:0]                      DO,
  input  logic                            RD,
  input  logic                            WR,
  output logic                            SCLK,
  output logic                            MOSI,
  input  logic                            MISO,
  output logic [NCS-1:0]                  nCS,
  input  logic [((NIN > 0) ? NIN : 1)-1:0] IN,
  output logic                            BUSY
);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [7:0]       div_q, div_d;
  logic [7:0]       divcnt_q, divcnt_d;
  logic [3:0]       edge_q, edge_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rxsh_q, rxsh_d;
  logic [7:0]       rx_q, rx_d;
  logic [NCS-1:0]   cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             ovr_q, ovr_d;

  logic             busy, edge_fire, last_edge, odd_edge;
  logic             rd_ev, start_wr, start_rd, start;
  logic [7:0]       tx_raw, tx_load;
  logic [5:0]       in_pad;
  logic [7:0]       cs_pad;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
  endfunction

  // A simultaneous WR masks every side effect of RD.
  assign rd_ev    = RD & ~WR;
  assign start_wr = WR & (A == 3'd0) & ~busy;
  assign start_rd = rd_ev & (A == 3'd0) & ~busy & ctrl_q[3];
  assign start    = start_wr | start_rd;

  always_ff @(posedge MHZ48) begin
    if (RES) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (edge_fire && last_edge) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_SHIFT);
    edge_fire = busy && (divcnt_q == div_q);
    last_edge = (edge_q == 4'd15);
    odd_edge  = ~edge_q[0];
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    div_d    = div_q;
    cs_d     = cs_q;
    divcnt_d = divcnt_q;
    edge_d   = edge_q;
    tx_d     = tx_q;
    rxsh_d   = rxsh_q;
    rx_d     = rx_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    tx_raw   = start_wr ? DI : 8'hFF;
    tx_load  = ctrl_q[2] ? rev8(tx_raw) : tx_raw;

    if (WR) begin
      case (A)
        3'd1: if (!busy) begin
          ctrl_d = DI[3:0];
          sclk_d = DI[0];
        end
        3'd2: if (!busy) div_d = DI;
        3'd3: cs_d = DI[NCS-1:0];
        default: ;
      endcase
    end

    ovr_d = (ovr_q & ~(rd_ev & (A == 3'd4))) | (WR & (A == 3'd0) & busy);

    if (start) begin
      divcnt_d = '0;
      edge_d   = '0;
      // CPHA=0 puts the first bit out immediately; CPHA=1 waits for edge 1.
      if (ctrl_q[1]) begin
        tx_d = tx_load;
      end else begin
        mosi_d = tx_load[7];
        tx_d   = {tx_load[6:0], 1'b0};
      end
    end else if (busy) begin
      if (edge_fire) begin
        divcnt_d = '0;
        edge_d   = edge_q + 4'd1;
        sclk_d   = ~sclk_q;
        if (ctrl_q[1] ? odd_edge : (!odd_edge && !last_edge)) begin
          mosi_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
        if (ctrl_q[1] ? !odd_edge : odd_edge) rxsh_d = {rxsh_q[6:0], MISO};
        if (last_edge) rx_d = ctrl_q[2] ? rev8(rxsh_d) : rxsh_d;
      end else begin
        divcnt_d = divcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge MHZ48) begin
    if (RES) begin
      ctrl_q   <= '0;
      div_q    <= DIV_RST;
      cs_q     <= '1;
      divcnt_q <= '0;
      edge_q   <= '0;
      tx_q     <= '0;
      rxsh_q   <= '0;
      rx_q     <= 8'hFF;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b1;
      ovr_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      div_q    <= div_d;
      cs_q     <= cs_d;
      divcnt_q <= divcnt_d;
      edge_q   <= edge_d;
      tx_q     <= tx_d;
      rxsh_q   <= rxsh_d;
      rx_q     <= rx_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ovr_q    <= ovr_d;
    end
  end

  generate
    if (NIN > 0) begin : g_in
      assign in_pad = 6'(IN);
    end else begin : g_no_in
      assign in_pad = '0;
    end
  endgenerate

  assign cs_pad = 8'(cs_q);

  always_comb begin
    case (A)
      3'd0:    DO = rx_q;
      3'd1:    DO = {4'b0000, ctrl_q};
      3'd2:    DO = div_q;
      3'd3:    DO = cs_pad;
      3'd4:    DO = {busy, ovr_q, in_pad};
      default: DO = 8'h00;
    endcase
  end

  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign nCS  = cs_q;
  assign BUSY = busy;

endmodule

// File: tb/tb_spi_master_n.sv
// Bench for spi_master_n: register table, per-cycle waveform model of each transfer,
// and hand-built sequences for busy writes, auto-read and mid-transfer reset.
module tb_spi_master_n;
  localparam int NCS = 4;
  localparam int NIN = 4;

  logic           clk = 1'b0;
  logic           res, rd, wr, miso;
  logic [2:0]     a;
  logic [7:0]     di, do_w;
  logic           sclk, mosi, busy;
  logic [NCS-1:0] ncs;
  logic [NIN-1:0] inp;

  int n_chk  = 0;
  int n_fail = 0;
  bit mdl_mosi;

  always #5 clk = ~clk;

  spi_master_n #(.NCS(NCS), .DIV_RST(8'd59), .NIN(NIN)) dut (
    .MHZ48(clk), .RES(res), .A(a), .DI(di), .DO(do_w), .RD(rd), .WR(wr),
    .SCLK(sclk), .MOSI(mosi), .MISO(miso), .nCS(ncs), .IN(inp), .BUSY(busy)
  );

  typedef struct {
    bit         wr;
    bit         rd;
    logic [2:0] a;
    logic [7:0] di;
    logic [3:0] in_v;
    logic [7:0] exp_do;
    logic [3:0] exp_ncs;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] a_v, input logic [7:0] d_v);
    a = a_v; di = d_v; wr = 1'b1;
    step();
    if (a_v == 3'd1) chk("ctrl_sclk_idle", sclk, d_v[0]);
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a_v, input logic [7:0] exp);
    a = a_v; rd = 1'b1;
    @(negedge clk);
    chk(nm, do_w, exp);
    step();
  endtask

  // Bit idx (0 = first on the wire) of byte b in the configured order.
  function automatic bit obit(input bit lsbf, input logic [7:0] b, input int idx);
    logic [7:0] t;
    t = b;
    return lsbf ? t[idx] : t[7-idx];
  endfunction

  // Whole-transfer model: n = edges already visible, from plain cycle arithmetic.
  task automatic do_xfer(input bit cpol, input bit cpha, input bit lsbf, input bit auto_m,
                         input int d, input logic [7:0] tx, input logic [7:0] slave,
                         input bit by_rd, input logic [7:0] exp_do, input bit busy_test,
                         input int abort_j);
    int n, m, k, last_j;
    bit pm, em;
    wr_reg(3'd1, {4'b0000, auto_m, lsbf, cpha, cpol});
    wr_reg(3'd2, d[7:0]);
    pm = mdl_mosi;
    a = 3'd0;
    if (by_rd) rd = 1'b1;
    else begin di = tx; wr = 1'b1; end
    @(negedge clk);
    chk("busy_at_start", busy, 1'b0);
    if (by_rd) chk("auto_rd_do", do_w, exp_do);
    step();
    last_j = 16 * (d + 1) + 1;
    for (int j = 1; j <= last_j; j++) begin
      n = (j - 1) / (d + 1);
      if (n > 16) n = 16;
      m = cpha ? ((n == 0) ? 0 : (n - 1) / 2) : n / 2;
      if (m > 7) m = 7;
      miso = obit(lsbf, slave, m);
      if (busy_test) begin
        case (j)
          5:       begin a = 3'd0; di = 8'h55; wr = 1'b1; end
          7:       begin a = 3'd2; di = 8'd9;  wr = 1'b1; end
          9, 11:   begin a = 3'd4; rd = 1'b1; end
          default: ;
        endcase
      end
      if (j == abort_j) res = 1'b1;
      @(negedge clk);
      chk("sclk", sclk, cpol ^ n[0]);
      if (!cpha) begin
        k = n / 2;
        if (k > 7) k = 7;
        em = obit(lsbf, tx, k);
      end else if (n == 0) begin
        em = pm;
      end else begin
        k = (n - 1) / 2;
        if (k > 7) k = 7;
        em = obit(lsbf, tx, k);
      end
      chk("mosi", mosi, em);
      chk("busy", busy, (j <= 16 * (d + 1)));
      if (busy_test && j == 9)  chk("status_busy_ovr", do_w, 8'hC0);
      if (busy_test && j == 11) chk("status_ovr_clr", do_w, 8'h80);
      step();
      if (j == abort_j) begin
        res = 1'b0;
        mdl_mosi = 1'b1;
        return;
      end
    end
    mdl_mosi = obit(lsbf, tx, 7);
  endtask

  initial begin
    bit          lb;
    int          dv;
    logic [7:0]  tx_r, sl_r;
    logic [3:0]  md;

    vt[0]  = '{0, 1, 3'd0, 8'h00, 4'h0, 8'hFF, 4'hF};
    vt[1]  = '{0, 1, 3'd1, 8'h00, 4'h0, 8'h00, 4'hF};
    vt[2]  = '{0, 1, 3'd2, 8'h00, 4'h0, 8'h3B, 4'hF};
    vt[3]  = '{0, 1, 3'd3, 8'h00, 4'h0, 8'h0F, 4'hF};
    vt[4]  = '{0, 1, 3'd4, 8'h00, 4'h0, 8'h00, 4'hF};
    vt[5]  = '{1, 0, 3'd3, 8'hFE, 4'h0, 8'h00, 4'hE};
    vt[6]  = '{1, 0, 3'd3, 8'hFD, 4'h0, 8'h00, 4'hD};
    vt[7]  = '{0, 1, 3'd4, 8'h00, 4'h5, 8'h05, 4'hD};
    vt[8]  = '{0, 1, 3'd4, 8'h00, 4'hA, 8'h0A, 4'hD};
    vt[9]  = '{0, 1, 3'd5, 8'h00, 4'hA, 8'h00, 4'hD};
    vt[10] = '{0, 1, 3'd6, 8'h00, 4'h3, 8'h00, 4'hD};
    vt[11] = '{0, 1, 3'd7, 8'h00, 4'h3, 8'h00, 4'hD};
    vt[12] = '{1, 0, 3'd5, 8'hFF, 4'h0, 8'h00, 4'hD};
    vt[13] = '{0, 1, 3'd3, 8'h00, 4'h0, 8'h0D, 4'hD};
    vt[14] = '{1, 1, 3'd3, 8'h0F, 4'h0, 8'h0D, 4'hF};
    vt[15] = '{0, 1, 3'd1, 8'h00, 4'h0, 8'h00, 4'hF};

    res = 1'b1; rd = 1'b0; wr = 1'b0; a = 3'd0; di = 8'h00; miso = 1'b1; inp = '0;
    repeat (3) @(posedge clk);
    #1 res = 1'b0;
    mdl_mosi = 1'b1;
    @(negedge clk);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b1);
    chk("rst_ncs", ncs, 4'hF);
    chk("rst_busy", busy, 1'b0);
    step();

    for (int i = 0; i < 16; i++) begin
      wr = vt[i].wr; rd = vt[i].rd; a = vt[i].a; di = vt[i].di; inp = vt[i].in_v;
      @(negedge clk);
      if (vt[i].rd) chk($sformatf("reg_do[%0d]", i), do_w, vt[i].exp_do);
      step();
      @(negedge clk);
      chk($sformatf("reg_ncs[%0d]", i), ncs, vt[i].exp_ncs);
      step();
    end
    inp = '0;

    // Mode 0, DIV=1, 0xA5 out / 0x3C in.
    do_xfer(0, 0, 0, 0, 1, 8'hA5, 8'h3C, 0, 8'h00, 0, 0);
    rd_chk("mode0_rx", 3'd0, 8'h3C);
    rd_chk("mode0_status", 3'd4, 8'h00);

    // Mode 3, LSB-first, DIV=0.
    do_xfer(1, 1, 1, 0, 0, 8'h01, 8'h80, 0, 8'h00, 0, 0);
    rd_chk("mode3_lsbf_rx", 3'd0, 8'h80);

    for (int it = 0; it < 12; it++) begin
      md   = 4'(it % 4);
      lb   = 1'($urandom_range(0, 1));
      dv   = int'($urandom_range(0, 4));
      tx_r = 8'($urandom);
      sl_r = 8'($urandom);
      do_xfer(md[0], md[1], lb, 0, dv, tx_r, sl_r, 0, 8'h00, 0, 0);
      rd_chk($sformatf("rand_rx[%0d]", it), 3'd0, sl_r);
    end

    // Writes while busy.
    do_xfer(0, 0, 0, 0, 3, 8'h96, 8'h5A, 0, 8'h00, 1, 0);
    rd_chk("busy_div_kept", 3'd2, 8'h03);
    rd_chk("busy_rx", 3'd0, 8'h5A);
    rd_chk("busy_ovr_gone", 3'd4, 8'h00);

    // Auto-restart reads from a fresh RX=0xFF.
    res = 1'b1;
    step();
    res = 1'b0;
    mdl_mosi = 1'b1;
    do_xfer(0, 0, 0, 1, 0, 8'hFF, 8'h11, 1, 8'hFF, 0, 0);
    do_xfer(0, 0, 0, 1, 0, 8'hFF, 8'h22, 1, 8'h11, 0, 0);
    do_xfer(0, 0, 0, 1, 0, 8'hFF, 8'h33, 1, 8'h22, 0, 0);
    wr_reg(3'd1, 8'h00);
    rd_chk("auto_last_rx", 3'd0, 8'h33);

    // Reset at edge 7 of a CPOL=1 transfer.
    wr_reg(3'd3, 8'h0E);
    do_xfer(1, 0, 0, 0, 2, 8'hC3, 8'hA5, 0, 8'h00, 0, 21);
    @(negedge clk);
    chk("abort_sclk", sclk, 1'b0);
    chk("abort_mosi", mosi, 1'b1);
    chk("abort_ncs", ncs, 4'hF);
    chk("abort_busy", busy, 1'b0);
    step();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("abort_no_edge", sclk, 1'b0);
      chk("abort_idle", busy, 1'b0);
      step();
    end
    rd_chk("abort_div", 3'd2, 8'h3B);
    rd_chk("abort_ctrl", 3'd1, 8'h00);
    rd_chk("abort_rx", 3'd0, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_n.md
Name: spi_master_n

Overview:
- Hardware SPI shift engine; replaces the bit-banged SCLK/MOSI/MISO address-toggle scheme in the glue CPLD.
- Supports a parametrised chip-select count, a programmable SCLK divider, all four SPI modes, LSB/MSB-first order, and an auto-restart read mode for block reads.
- Sits behind the I/O decoder at $FE30-$FE37. The decoder supplies single-cycle RD/WR strobes synchronous to MHZ48.

Parameters:
- NCS, 4, number of active-low chip-select outputs (1..8).
- DIV_RST, 8'd59, divider reset value; SCLK half-period = DIV+1 MHZ48 cycles (reset value gives 400 kHz).
- NIN, 4, number of status input pins (card-detect/write-protect), 0..6.

Ports:
- MHZ48  in  1  master clock, all logic on rising edge
- RES  in  1  synchronous reset, active-high
- A  in  3  register offset
- DI  in  8  write data
- DO  out  8  read data; combinational mux of A, valid whenever RD=1
- RD  in  1  read strobe, one MHZ48 cycle per access
- WR  in  1  write strobe, one MHZ48 cycle per access
- SCLK  out  1  SPI clock, registered
- MOSI  out  1  SPI data out, registered
- MISO  in  1  SPI data in; assumed stable, no synchroniser
- nCS  out  NCS  chip selects, registered
- IN  in  NIN  status inputs
- BUSY  out  1  transfer in progress (mirrors STATUS bit 7)

Behaviour:
- Registers:
  - 0 DATA: write = TX byte and start; read = last RX byte.
  - 1 CTRL: b0 CPOL, b1 CPHA, b2 LSBF, b3 AUTO; other bits read 0.
  - 2 DIV: 8-bit divider value.
  - 3 CS: bits [NCS-1:0] drive nCS directly; 1 = deselected.
  - 4 STATUS: b7 BUSY, b6 OVR, b[NIN-1:0] = IN.
  - 5-7: read 0x00; writes ignored.
- Reset values: SCLK=0, MOSI=1, nCS=all 1, CTRL=0, DIV=DIV_RST, RX=0xFF, BUSY=0, OVR=0, FSM in IDLE.
- RES mid-transfer aborts at once. No further SCLK edges occur and all outputs take their reset values.
- FSM states:
  - IDLE -> SHIFT on a start event.
  - SHIFT -> IDLE after edge 16.
- Start events:
  - WR to DATA while IDLE.
  - RD of DATA while IDLE with AUTO=1; this transmits 0xFF, and DO returns the RX value held before the new transfer.
- At the start cycle T:
  - Shift register loads the TX byte, bit-reversed if LSBF=1.
  - BUSY=1 from T+1.
  - Divider counter and edge counter both clear.
- Edge timing:
  - Edge k (k=1..16) is the SCLK toggle at cycle T+k*(DIV+1).
  - Odd k = leading edge, even k = trailing edge.
- CPHA=0:
  - MOSI = first bit at T+1.
  - Sample MISO on odd edges; next bit on MOSI at even edges 2..14.
- CPHA=1:
  - MOSI updates on odd edges.
  - Sample MISO on even edges.
- Sampled bits shift into the RX shift register, MSB-first. RX is bit-reversed into DATA if LSBF=1.
- Completion:
  - At edge 16, DATA/RX update and BUSY=0 from the next cycle.
  - The full transfer is 16*(DIV+1)+1 cycles from the WR cycle to BUSY low.
  - MOSI holds its last bit after completion.
- SCLK idle level = CPOL. A CPOL write while IDLE moves SCLK on the next cycle.
- Writes while BUSY:
  - DATA write is ignored and sets OVR.
  - CTRL and DIV writes are ignored.
  - CS writes take effect immediately; software is responsible for this.
- OVR is sticky and clears on a STATUS read. If the set and clear land in the same cycle, set wins.
- Simultaneous RD and WR: WR takes priority and RD side effects are suppressed.
- DIV=0 gives SCLK = MHZ48/2. No divider value is illegal.

Test Plan:
- Mode 0, DIV=1, slave returns 0x3C, write DATA=0xA5 -> SCLK toggles every 2 cycles, 16 edges; MOSI bits 1,0,1,0,0,1,0,1 on rising edges; BUSY low after 33 cycles; DATA reads 0x3C; OVR=0.
- CTRL=0x07 (mode 3, LSBF), DIV=0, write 0x01, slave returns 0x80 (LSB-first) -> SCLK idles 1; MOSI changes on falling edges with first bit 1; DATA reads 0x80 after LSB-first reassembly; check against the bench model for all 4 modes.
- During BUSY, write DATA=0x55 and write DIV=9 -> transfer continues at the original rate and original byte; STATUS reads 0xC0 while busy, then OVR reads 0 on the next STATUS read.
- AUTO=1, three consecutive DATA reads with slave bytes 0x11, 0x22 -> first read returns 0xFF and starts a transfer with MOSI=0xFF; the reads after completion return 0x11, then 0x22.
- Assert RES at edge 7 of a transfer -> next cycle SCLK=0, MOSI=1, nCS=all 1, BUSY=0, DIV=DIV_RST; no further edges occur.
- Write CS=0xFE, then 0xFD; toggle IN -> nCS follows on the next cycle each time; STATUS low bits track IN; offsets 5-7 read 0x00.
